// File: rtl/boruss_alu_pkg.sv
// boruss_alu_pkg: opcode map and data width shared by the ALU and the control unit
package boruss_alu_pkg;
    localparam int DATA_W = 8;
    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_NOT = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_JMP = 8'h08;
    localparam logic [7:0] OP_JZ  = 8'h09;
    localparam logic [7:0] OP_JNZ = 8'h0A;
    localparam logic [7:0] OP_JC  = 8'h0B;
    localparam logic [7:0] OP_JNC = 8'h0C;
    localparam logic [7:0] OP_JN  = 8'h0D;
    localparam logic [7:0] OP_JNN = 8'h0E;
    localparam logic [7:0] OP_CMP = 8'h0F;
endpackage

// File: rtl/boruss_alu_if.sv
// boruss_alu_if: operand/opcode bus into the ALU and registered result/flags back out
interface boruss_alu_if;
    import boruss_alu_pkg::*;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [7:0]        operation_code;
    logic [DATA_W-1:0] result;
    logic              zero_flag;
    logic              carry_flag;
    logic              negative_flag;
    modport master (
        output operand_a, operand_b, operation_code,
        input  result, zero_flag, carry_flag, negative_flag
    );
    modport slave (
        input  operand_a, operand_b, operation_code,
        output result, zero_flag, carry_flag, negative_flag
    );
endinterface

// File: rtl/boruss_alu_comb.sv
// boruss_alu_comb: opcode decode producing next result and Z/C/N flags
module boruss_alu_comb
    import boruss_alu_pkg::*;
(
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              c,
    output logic              z,
    output logic              n
);
    always_comb begin
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD:                 {c, r} = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP:         {c, r} = {1'b0, a} - {1'b0, b};
            OP_AND:                 r = a & b;
            OP_OR:                  r = a | b;
            OP_XOR:                 r = a ^ b;
            OP_NOT:                 r = ~a;
            OP_SHL:                 {c, r} = {a, 1'b0};
            OP_SHR:                 {r, c} = {1'b0, a};
            OP_JMP, OP_JZ, OP_JNZ, OP_JC,
            OP_JNC, OP_JN, OP_JNN:  r = b;
            default:                r = '0;
        endcase
    end
    assign z = (r == '0);
    assign n = r[DATA_W-1];
endmodule

// File: rtl/boruss_alu.sv
// boruss_alu: registered 8-bit ALU; one-cycle latency, reset clears result and flags
module boruss_alu
    import boruss_alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    boruss_alu_if.slave    bus
);
    logic [DATA_W-1:0] r_nxt;
    logic              c_nxt;
    logic              z_nxt;
    logic              n_nxt;

    boruss_alu_comb u_comb (
        .op (bus.operation_code),
        .a  (bus.operand_a),
        .b  (bus.operand_b),
        .r  (r_nxt),
        .c  (c_nxt),
        .z  (z_nxt),
        .n  (n_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result        <= '0;
            bus.zero_flag     <= 1'b0;
            bus.carry_flag    <= 1'b0;
            bus.negative_flag <= 1'b0;
        end else begin
            bus.result        <= r_nxt;
            bus.zero_flag     <= z_nxt;
            bus.carry_flag    <= c_nxt;
            bus.negative_flag <= n_nxt;
        end
    end
endmodule

// File: tb/tb_boruss_alu.sv
// tb_boruss_alu: directed vector table plus reset, undefined-opcode and latency sequences
module tb_boruss_alu;
    import boruss_alu_pkg::*;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;

    boruss_alu_if bus ();

    boruss_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] r, input logic z, input logic c, input logic n);
        total++;
        if ({bus.result, bus.zero_flag, bus.carry_flag, bus.negative_flag} !== {r, z, c, n})
            $display("FAIL %s: got r=%02h z=%0b c=%0b n=%0b, want r=%02h z=%0b c=%0b n=%0b",
                     nm, bus.result, bus.zero_flag, bus.carry_flag, bus.negative_flag, r, z, c, n);
        else
            passed++;
    endtask

    task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.operation_code = op;
        bus.operand_a      = a;
        bus.operand_b      = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_SUB, 8'h05, 8'h0A, 8'hFB, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{OP_CMP, 8'h0F, 8'h0A, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_CMP, 8'h05, 8'h0F, 8'hF6, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{OP_AND, 8'hF0, 8'hAA, 8'hA0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_NOT, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_SHL, 8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{OP_SHL, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{OP_SHR, 8'hAA, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_SHR, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{OP_JMP, 8'h11, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{OP_JMP, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{OP_JNC, 8'hFF, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{OP_JZ,  8'h01, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{OP_JNZ, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{OP_JC,  8'h80, 8'h22, 8'h22, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{OP_JN,  8'h80, 8'h91, 8'h91, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{OP_JNN, 8'hFF, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{8'h20,  8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};

        drive(OP_ADD, 8'd10, 8'd5);
        step();
        chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("post_reset_add", 8'd15, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            chk($sformatf("vec%0d_op%02h", i, vecs[i].op), vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].n);
        end

        drive(8'hFF, 8'd42, 8'd24);
        step();
        chk("undef_ff", 8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h10, 8'd42, 8'd24);
        step();
        chk("undef_10", 8'h00, 1'b1, 1'b0, 1'b0);

        begin
            logic [8:0] exp_prev;
            logic [8:0] exp_cur;
            exp_prev = '0;
            for (int i = 0; i < 8; i++) begin
                logic [7:0] a;
                logic [7:0] b;
                a = 8'(i * 37 + 3);
                b = 8'(i * 29 + 11);
                exp_cur = (i % 2 == 0) ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
                drive((i % 2 == 0) ? OP_ADD : OP_SUB, a, b);
                #1;
                if (i > 0)
                    chk($sformatf("hold%0d", i), exp_prev[7:0], exp_prev[7:0] == 8'h00, exp_prev[8], exp_prev[7]);
                step();
                chk($sformatf("alt%0d", i), exp_cur[7:0], exp_cur[7:0] == 8'h00, exp_cur[8], exp_cur[7]);
                exp_prev = exp_cur;
            end
        end

        drive(OP_ADD, 8'hFF, 8'hFF);
        rst = 1'b1;
        step();
        chk("midstream_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("after_midstream_reset", 8'hFE, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/boruss_alu.md
Name: boruss_alu

Overview:
- 8-bit ALU for the Boruss CPU datapath; computes one of 16 operations on operand_a/operand_b selected by an 8-bit opcode.
- Registered result plus Z/C/N status flags are consumed by the register file, the flag register and the PC-update logic.
- Jump opcodes pass the target address (operand_b) through to result so the PC logic can load it.

Parameters:
- none (data width fixed at 8; opcode width fixed at 8)

Ports:
- clk  in  1  single system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- operand_a  in  8  first operand (shifted/inverted operand for unary ops)
- operand_b  in  8  second operand; jump target address for opcodes 0x08-0x0E
- operation_code  in  8  opcode select
- result  out  8  registered operation result
- zero_flag  out  1  registered; 1 when the next result is 0x00
- carry_flag  out  1  registered; carry/borrow/shifted-out bit
- negative_flag  out  1  registered; equals next result[7]

Behaviour:
- All outputs registered; latency 1 cycle.
- Inputs sampled on every rising clk edge; outputs reflect the operation on inputs present at the previous edge. No enable, no handshake; a new operation may be issued every cycle.
- rst=1 at a rising edge: result=0x00, zero_flag=0, carry_flag=0, negative_flag=0. Reset has priority over computation, including mid-stream.
- Opcode map (A=operand_a, B=operand_b, R=next result, C=next carry):
  - 0x00 ADD: R=(A+B)[7:0]; C=bit 8 of the 9-bit sum.
  - 0x01 SUB: R=(A-B)[7:0]; C=1 iff A<B unsigned (borrow).
  - 0x02 AND: R=A&B; C=0.
  - 0x03 OR: R=A|B; C=0.
  - 0x04 XOR: R=A^B; C=0.
  - 0x05 NOT: R=~A; B ignored; C=0.
  - 0x06 SHL: R={A[6:0],0}; C=A[7].
  - 0x07 SHR: R={0,A[7:1]} (logical); C=A[0].
  - 0x08 JMP, 0x09 JZ, 0x0A JNZ, 0x0B JC, 0x0C JNC, 0x0D JN, 0x0E JNN: R=B; C=0.
    - The ALU does not evaluate the jump condition; the control unit does, using the flag register.
  - 0x0F CMP: identical to SUB (R and C as SUB); result is driven, and the consumer decides whether to write it back.
  - 0x10-0xFF: R=0x00; C=0.
- For every opcode, including jumps and undefined opcodes: zero_flag=(R==0), negative_flag=R[7].
  - Undefined opcode therefore yields Z=1, N=0, C=0.
- No signed-overflow flag.
- Full opcode decoded on all 8 bits; 0x10 is not aliased to 0x00.

Decomposition:
- Package boruss_alu_pkg: opcode localparams (OP_ADD=0x00 … OP_CMP=0x0F) and data-width constant 8, shared with the decoder/control unit.
- One combinational sub-module, boruss_alu_comb: case on opcode producing next R and C, plus Z/N derivation.
- Top boruss_alu holds only the output registers and reset.

Test Plan:
- Reset: hold rst=1 with A=10,B=5,op=0x00 for one edge -> result=0x00, Z=0,C=0,N=0. Release; one edge later -> result=15, Z=0,C=0,N=0.
- Arithmetic: ADD 255+1 -> 0x00, Z=1,C=1,N=0. SUB 5-5 -> 0x00, Z=1,C=0. SUB 5-10 -> 0xFB, Z=0,C=1,N=1. CMP 15-10 -> 0x05, all flags 0. CMP 5-15 -> 0xF6, C=1,N=1.
- Logic: AND F0&AA -> A0, N=1. OR F0|0F -> FF, N=1. XOR AA^AA -> 00, Z=1. NOT AA -> 55, all flags 0.
- Shifts: SHL 0x55 -> AA, N=1,C=0. SHL 0x80 -> 00, Z=1,C=1. SHR 0xAA -> 55, C=0. SHR 0x01 -> 00, Z=1,C=1.
- Jumps: JMP B=0x40 -> 0x40, flags 0. JMP B=0x00 -> 0x00, Z=1. JNC B=0x80 -> 0x80, N=1,C=0. JZ B=0xFF -> 0xFF, N=1.
- Undefined/back-to-back: op=0xFF then op=0x10 on consecutive cycles (A=42,B=24) -> result 0x00, Z=1,C=0,N=0 each cycle. Alternate ADD/SUB every cycle -> each result appears exactly one cycle after its inputs.
